// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_IC_READ  = 2'd1,
        ST_LS_READ  = 2'd2,
        ST_LS_WRITE = 2'd3
    } arb_state_e;

    typedef enum logic {
        GRANT_ICACHE = 1'b0,
        GRANT_LSB    = 1'b1
    } grant_e;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Value of address bits [17:16] that selects the IO region
    localparam logic [1:0] IO_REGION = 2'b11;

    // Number of bytes moved by a load/store; the reserved code 11 acts as a word
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            SIZE_WORD: return 3'd4;
            default:   return 3'd4;
        endcase
    endfunction

    function automatic logic is_io_addr(input logic [1:0] addr_hi);
        return addr_hi == IO_REGION;
    endfunction

endpackage

// File: rtl/mem_word_assembler.sv
// Byte-lane merge of a read byte into the load word, and byte select of store data.
module mem_word_assembler
    import mem_arbiter_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [7:0]  din_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_merged_c,
    output logic [7:0]  wbyte_c
);

    // Replace one byte lane of the load word and pick one byte of the store word
    always_comb begin
        rdata_merged_c                         = rdata_i;
        rdata_merged_c[{lane_i, 3'b000} +: 8]  = din_i;
        wbyte_c                                = wdata_i[{lane_i, 3'b000} +: 8];
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port byte memory arbiter between an instruction-cache filler and a load/store unit.
// Optional: define MEM_ARBITER_IO_STALL_EN to add io_buffer_full stalling of IO-region stores.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ICACHE_BURST = 18,
    parameter int unsigned ADDR_WIDTH   = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  clear_in,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  icache_req,
    input  logic [ADDR_WIDTH-1:0] icache_addr,
    output logic [7:0]            icache_data,
    output logic                  icache_data_valid,
    output logic                  icache_done,
    input  logic                  lsb_req,
    input  logic                  lsb_wr,
    input  logic [1:0]            lsb_size,
    input  logic [ADDR_WIDTH-1:0] lsb_addr,
    input  logic [31:0]           lsb_wdata,
    output logic [31:0]           lsb_rdata,
    output logic                  lsb_done
`ifdef MEM_ARBITER_IO_STALL_EN
    ,
    input  logic                  io_buffer_full
`endif
);

    localparam int unsigned CNT_W = $clog2(ICACHE_BURST + 6);
    localparam logic [CNT_W-1:0] IC_LEN  = CNT_W'(ICACHE_BURST);
    localparam logic [CNT_W-1:0] IC_DONE = CNT_W'(ICACHE_BURST + 1);

    arb_state_e            state_q;
    grant_e                last_grant_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_p1;
    logic [CNT_W-1:0]      size_cnt;
    logic [2:0]            size_q;
    logic [31:0]           wdata_q;
    logic [ADDR_WIDTH-1:0] mem_a_q;
    logic [7:0]            mem_dout_q;
    logic                  mem_wr_q;
    logic                  ic_valid_q;
    logic                  ic_done_q;
    logic [31:0]           rdata_q;
    logic                  ls_done_q;
    logic [1:0]            lane_c;
    logic [31:0]           rdata_merged_c;
    logic [7:0]            wbyte_c;
    logic                  stall_c;

    assign cnt_p1   = cnt_q + CNT_W'(1);
    assign size_cnt = CNT_W'(size_q);
    // Writes prepare the next byte; reads merge the byte addressed one cycle earlier
    assign lane_c   = (state_q == ST_LS_WRITE) ? cnt_q[1:0] + 2'd1 : cnt_q[1:0] - 2'd1;

    mem_word_assembler u_assembler (
        .rdata_i        (rdata_q),
        .din_i          (mem_din),
        .lane_i         (lane_c),
        .wdata_i        (wdata_q),
        .rdata_merged_c (rdata_merged_c),
        .wbyte_c        (wbyte_c)
    );

`ifdef MEM_ARBITER_IO_STALL_EN
    logic io_q;

    // Remember whether the store being granted targets the IO region
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            io_q <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            io_q <= is_io_addr(lsb_addr[17:16]);
        end
    end

    assign stall_c = (state_q == ST_LS_WRITE) && mem_wr_q && io_q && io_buffer_full;
`else
    assign stall_c = 1'b0;
`endif

    assign mem_a             = mem_a_q;
    assign mem_dout          = mem_dout_q;
    assign mem_wr            = mem_wr_q & ~stall_c;
    assign icache_data       = ic_valid_q ? mem_din : 8'h00;
    assign icache_data_valid = ic_valid_q;
    assign icache_done       = ic_done_q;
    assign lsb_rdata         = rdata_q;
    assign lsb_done          = ls_done_q;

    // Arbitration FSM with registered memory-side and client-side outputs
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_LSB;
            cnt_q        <= '0;
            size_q       <= 3'd0;
            wdata_q      <= 32'h0;
            mem_a_q      <= '0;
            mem_dout_q   <= 8'h00;
            mem_wr_q     <= 1'b0;
            ic_valid_q   <= 1'b0;
            ic_done_q    <= 1'b0;
            rdata_q      <= 32'h0;
            ls_done_q    <= 1'b0;
        end else begin
            ic_done_q <= 1'b0;
            ls_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    ic_valid_q <= 1'b0;
                    mem_wr_q   <= 1'b0;
                    cnt_q      <= '0;
                    if (icache_req && (!lsb_req || last_grant_q == GRANT_LSB)) begin
                        state_q      <= ST_IC_READ;
                        last_grant_q <= GRANT_ICACHE;
                        mem_a_q      <= icache_addr;
                    end else if (lsb_req) begin
                        last_grant_q <= GRANT_LSB;
                        mem_a_q      <= lsb_addr;
                        size_q       <= size_bytes(lsb_size);
                        wdata_q      <= lsb_wdata;
                        if (lsb_wr) begin
                            state_q    <= ST_LS_WRITE;
                            mem_wr_q   <= 1'b1;
                            mem_dout_q <= lsb_wdata[7:0];
                        end else begin
                            state_q <= ST_LS_READ;
                            rdata_q <= 32'h0;
                        end
                    end
                end
                ST_IC_READ: begin
                    if (clear_in) begin
                        state_q    <= ST_IDLE;
                        ic_valid_q <= 1'b0;
                    end else begin
                        cnt_q      <= cnt_p1;
                        ic_valid_q <= (cnt_p1 <= IC_LEN);
                        ic_done_q  <= (cnt_p1 == IC_DONE);
                        if (cnt_p1 < IC_LEN) begin
                            mem_a_q <= mem_a_q + ADDR_WIDTH'(1);
                        end
                        if (cnt_q == IC_DONE) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_LS_READ: begin
                    if (clear_in) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q     <= cnt_p1;
                        ls_done_q <= (cnt_p1 == size_cnt + CNT_W'(1));
                        if (cnt_p1 < size_cnt) begin
                            mem_a_q <= mem_a_q + ADDR_WIDTH'(1);
                        end
                        if (cnt_q != '0 && cnt_q <= size_cnt) begin
                            rdata_q <= rdata_merged_c;
                        end
                        if (cnt_q == size_cnt + CNT_W'(1)) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_LS_WRITE: begin
                    // Stores ignore clear_in and always run to completion
                    if (!mem_wr_q) begin
                        state_q <= ST_IDLE;
                    end else if (!stall_c) begin
                        if (cnt_p1 < size_cnt) begin
                            cnt_q      <= cnt_p1;
                            mem_a_q    <= mem_a_q + ADDR_WIDTH'(1);
                            mem_dout_q <= wbyte_c;
                        end else begin
                            mem_wr_q  <= 1'b0;
                            ls_done_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter with a transaction-level reference model.
module tb_mem_arbiter;

    localparam int unsigned B = 18;

    logic        clk;
    logic        rst_n;
    logic        clear_in;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic [7:0]  icache_data;
    logic        icache_data_valid;
    logic        icache_done;
    logic        lsb_req;
    logic        lsb_wr;
    logic [1:0]  lsb_size;
    logic [31:0] lsb_addr;
    logic [31:0] lsb_wdata;
    logic [31:0] lsb_rdata;
    logic        lsb_done;

    int n_total = 0;
    int n_bad   = 0;
    logic model_last_lsb;

    mem_arbiter #(.ICACHE_BURST(B), .ADDR_WIDTH(32)) dut (
        .clk_in            (clk),
        .rst_in            (rst_n),
        .clear_in          (clear_in),
        .mem_din           (mem_din),
        .mem_dout          (mem_dout),
        .mem_a             (mem_a),
        .mem_wr            (mem_wr),
        .icache_req        (icache_req),
        .icache_addr       (icache_addr),
        .icache_data       (icache_data),
        .icache_data_valid (icache_data_valid),
        .icache_done       (icache_done),
        .lsb_req           (lsb_req),
        .lsb_wr            (lsb_wr),
        .lsb_size          (lsb_size),
        .lsb_addr          (lsb_addr),
        .lsb_wdata         (lsb_wdata),
        .lsb_rdata         (lsb_rdata),
        .lsb_done          (lsb_done)
`ifdef MEM_ARBITER_IO_STALL_EN
        ,
        .io_buffer_full    (1'b0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte memory: unwritten locations hold a fixed address hash
    logic [7:0] mem [logic [31:0]];

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    always @(posedge clk) begin
        if (mem_wr) mem[mem_a] = mem_dout;
        mem_din <= mem_rd(mem_a);
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic quiet(input int n, input logic [31:0] exp_a);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk_eq("idle_addr", mem_a, exp_a);
            chk_eq("idle_wr", 32'(mem_wr), 32'd0);
            chk_eq("idle_vld", 32'(icache_data_valid), 32'd0);
            chk_eq("idle_icdone", 32'(icache_done), 32'd0);
            chk_eq("idle_lsdone", 32'(lsb_done), 32'd0);
        end
    endtask

    // Instruction fill: address k in cycle k, byte k in cycle k+1, done in cycle B+1
    task automatic ic_txn(input logic [31:0] addr, input int clear_at);
        logic [31:0] last_a;
        icache_req = 1'b1;
        icache_addr = addr;
        model_last_lsb = 1'b0;
        last_a = addr + 32'(B - 1);
        for (int c = 0; c <= int'(B) + 1; c++) begin
            @(negedge clk);
            chk_eq("ic_addr", mem_a, addr + 32'((c < int'(B)) ? c : int'(B) - 1));
            chk_eq("ic_wr", 32'(mem_wr), 32'd0);
            chk_eq("ic_vld", 32'(icache_data_valid), 32'(c >= 1 && c <= int'(B)));
            if (c >= 1 && c <= int'(B))
                chk_eq("ic_data", 32'(icache_data), 32'(mem_rd(addr + 32'(c - 1))));
            chk_eq("ic_done", 32'(icache_done), 32'(c == int'(B) + 1));
            chk_eq("ic_lsdone", 32'(lsb_done), 32'd0);
            if (c == clear_at) begin
                clear_in = 1'b1;
                icache_req = 1'b0;
                last_a = addr + 32'((c < int'(B)) ? c : int'(B) - 1);
                break;
            end
            if (c == int'(B) + 1) icache_req = 1'b0;
        end
        quiet(1, last_a);
        clear_in = 1'b0;
    endtask

    // Load/store of S bytes, little-endian from addr
    task automatic lsb_txn(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, input int clear_at);
        int s;
        logic [31:0] exp_rd;
        logic [31:0] last_a;
        logic [31:0] sh;
        s = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        exp_rd = 32'h0;
        for (int k = 0; k < s; k++)
            exp_rd = exp_rd | (32'(mem_rd(addr + 32'(k))) << (8 * k));
        lsb_req = 1'b1;
        lsb_wr = wr;
        lsb_size = size;
        lsb_addr = addr;
        lsb_wdata = wdata;
        model_last_lsb = 1'b1;
        last_a = addr + 32'(s - 1);
        if (!wr) begin
            for (int c = 0; c <= s + 1; c++) begin
                @(negedge clk);
                chk_eq("ld_addr", mem_a, addr + 32'((c < s) ? c : s - 1));
                chk_eq("ld_wr", 32'(mem_wr), 32'd0);
                chk_eq("ld_vld", 32'(icache_data_valid), 32'd0);
                chk_eq("ld_done", 32'(lsb_done), 32'(c == s + 1));
                if (c == s + 1) chk_eq("ld_rdata", lsb_rdata, exp_rd);
                if (c == clear_at) begin
                    clear_in = 1'b1;
                    lsb_req = 1'b0;
                    last_a = addr + 32'((c < s) ? c : s - 1);
                    break;
                end
                if (c == s + 1) lsb_req = 1'b0;
            end
        end else begin
            for (int c = 0; c <= s; c++) begin
                @(negedge clk);
                chk_eq("st_addr", mem_a, addr + 32'((c < s) ? c : s - 1));
                chk_eq("st_wr", 32'(mem_wr), 32'(c < s));
                if (c < s) begin
                    sh = wdata >> (8 * c);
                    chk_eq("st_dout", 32'(mem_dout), sh & 32'hFF);
                end
                chk_eq("st_done", 32'(lsb_done), 32'(c == s));
                clear_in = (c == clear_at);
                if (c == s) lsb_req = 1'b0;
            end
            clear_in = 1'b0;
            for (int k = 0; k < s; k++) begin
                sh = wdata >> (8 * k);
                chk_eq("st_mem", 32'(mem_rd(addr + 32'(k))), sh & 32'hFF);
            end
        end
        quiet(1, last_a);
        clear_in = 1'b0;
    endtask

    // Both requesters raised together; the one not granted last goes first
    task automatic conflict(input logic [31:0] ia, input logic w, input logic [1:0] sz,
                            input logic [31:0] la, input logic [31:0] wd);
        icache_req = 1'b1;
        icache_addr = ia;
        lsb_req = 1'b1;
        lsb_wr = w;
        lsb_size = sz;
        lsb_addr = la;
        lsb_wdata = wd;
        if (model_last_lsb) begin
            ic_txn(ia, -1);
            lsb_txn(w, sz, la, wd, -1);
        end else begin
            lsb_txn(w, sz, la, wd, -1);
            ic_txn(ia, -1);
        end
    endtask

    task automatic chk_all_zero();
        chk_eq("rst_a", mem_a, 32'h0);
        chk_eq("rst_dout", 32'(mem_dout), 32'h0);
        chk_eq("rst_wr", 32'(mem_wr), 32'h0);
        chk_eq("rst_icdata", 32'(icache_data), 32'h0);
        chk_eq("rst_vld", 32'(icache_data_valid), 32'h0);
        chk_eq("rst_icdone", 32'(icache_done), 32'h0);
        chk_eq("rst_rdata", lsb_rdata, 32'h0);
        chk_eq("rst_lsdone", 32'(lsb_done), 32'h0);
    endtask

    initial begin
        rst_n = 1'b1;
        clear_in = 1'b0;
        icache_req = 1'b0;
        icache_addr = 32'h0;
        lsb_req = 1'b0;
        lsb_wr = 1'b0;
        lsb_size = 2'b00;
        lsb_addr = 32'h0;
        lsb_wdata = 32'h0;
        mem[32'h0000_1003] = 8'hAB;
        mem[32'h0000_1004] = 8'hCD;
        #2 rst_n = 1'b0;
        model_last_lsb = 1'b1;
        repeat (2) @(negedge clk);
        chk_all_zero();
        rst_n = 1'b1;
        quiet(2, 32'h0);

        // First conflict after reset: fill at 0x100 wins, then the half load at 0x1003
        conflict(32'h0000_0100, 1'b0, 2'b01, 32'h0000_1003, 32'h0);
        chk_eq("ld_cdab", lsb_rdata, 32'h0000_CDAB);

        // Word store 0x11223344 at 0x2000
        lsb_txn(1'b1, 2'b10, 32'h0000_2000, 32'h1122_3344, -1);
        chk_eq("st_word", {mem_rd(32'h2003), mem_rd(32'h2002), mem_rd(32'h2001), mem_rd(32'h2000)},
               32'h1122_3344);

        // Fill flushed in its cycle 5, then stays silent; the flushed grant still counts
        ic_txn(32'h0000_0300, 5);
        quiet(20, 32'h0000_0305);
        conflict(32'h0000_0500, 1'b0, 2'b00, 32'h0000_1004, 32'h0);

        // Flush during a word store has no effect
        lsb_txn(1'b1, 2'b10, 32'h0000_2100, 32'hDEAD_BEEF, 1);

        // Reset during store cycle 2
        lsb_req = 1'b1;
        lsb_wr = 1'b1;
        lsb_size = 2'b10;
        lsb_addr = 32'h0000_2200;
        lsb_wdata = 32'hA1B2_C3D4;
        repeat (3) @(negedge clk);
        chk_eq("rstmid_wr", 32'(mem_wr), 32'd1);
        chk_eq("rstmid_a", mem_a, 32'h0000_2202);
        rst_n = 1'b0;
        lsb_req = 1'b0;
        #1;
        chk_all_zero();
        @(negedge clk);
        rst_n = 1'b1;
        model_last_lsb = 1'b1;
        quiet(3, 32'h0);
        conflict(32'h0000_0400, 1'b0, 2'b10, 32'h0000_1000, 32'h0);

        // Random mix of solo, flushed and conflicting transactions
        for (int i = 0; i < 40; i++) begin
            logic [31:0] ia;
            logic [31:0] la;
            logic [31:0] wd;
            logic [1:0]  sz;
            logic        w;
            int          kind;
            int          clr;
            int          s;
            ia = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
            la = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : $urandom;
            sz = 2'($urandom_range(0, 3));
            w = 1'($urandom_range(0, 1));
            wd = $urandom;
            s = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
            kind = int'($urandom_range(0, 2));
            clr = -1;
            case (kind)
                0: begin
                    if ($urandom_range(0, 3) == 0) clr = int'($urandom_range(0, B));
                    ic_txn(ia, clr);
                end
                1: begin
                    if ($urandom_range(0, 3) == 0)
                        clr = w ? int'($urandom_range(0, 32'(s - 1))) : int'($urandom_range(0, 32'(s)));
                    lsb_txn(w, sz, la, wd, clr);
                end
                default: conflict(ia, w, sz, la, wd);
            endcase
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ICACHE_BURST, default 18, bytes per instruction-cache fill burst.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, memory address width.
REQ-003 SHALL have ports, in order:
- clk_in  input  1  sole clock; all state updates on rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- clear_in  input  1  pipeline flush; aborts speculative reads.
- mem_din  input  8  read byte from memory, valid one cycle after its address.
- mem_dout  output  8  write byte.
- mem_a  output  ADDR_WIDTH  memory byte address.
- mem_wr  output  1  1 = write this cycle.
- icache_req  input  1  fill request, level-held until done.
- icache_addr  input  ADDR_WIDTH  burst base address.
- icache_data  output  8  fill byte.
- icache_data_valid  output  1  icache_data carries next burst byte.
- icache_done  output  1  one-cycle pulse after the final burst byte.
- lsb_req  input  1  load/store request, level-held until lsb_done.
- lsb_wr  input  1  1 = store.
- lsb_size  input  2  00 byte, 01 half, 10 word; 11 treated as word.
- lsb_addr  input  ADDR_WIDTH  first byte address, little-endian.
- lsb_wdata  input  32  store data; low bytes used.
- lsb_rdata  output  32  load data, zero-extended.
- lsb_done  output  1  one-cycle completion pulse.

Function
REQ-004 SHALL implement states IDLE, IC_READ, LS_READ, LS_WRITE.
REQ-005 In IDLE with one requester, SHALL grant it next cycle; with both, SHALL grant the one not granted last, tracked in a last_grant bit.
REQ-006 SHALL never preempt a granted transaction, except per REQ-011.
REQ-007 IC_READ SHALL drive mem_a = icache_addr+k in grant cycle k, for k = 0..ICACHE_BURST-1.
- Byte k SHALL appear on icache_data with icache_data_valid in cycle k+1.
- icache_done SHALL pulse in cycle ICACHE_BURST+1, then return to IDLE.
REQ-008 LS_READ SHALL issue S addresses, S = 1/2/4 from lsb_size, and place byte k at lsb_rdata[8k+7:8k].
- lsb_done SHALL pulse in cycle S+1 with lsb_rdata stable.
- Unused upper bytes SHALL be 0.
REQ-009 LS_WRITE SHALL drive mem_wr=1, mem_a=lsb_addr+k, mem_dout=lsb_wdata[8k+7:8k] for k = 0..S-1.
- lsb_done SHALL pulse in cycle S, with mem_wr=0 that cycle.
REQ-010 Address increments SHALL be modulo 2^ADDR_WIDTH; mem_wr SHALL be 0 in every non-LS_WRITE cycle.
REQ-011 clear_in=1 in IC_READ or LS_READ SHALL return to IDLE next cycle.
- No further valid/done pulse for the aborted transaction.
- last_grant SHALL be unchanged.
REQ-012 clear_in SHALL NOT affect LS_WRITE; the store SHALL complete.
REQ-013 A request deasserted mid-transaction SHALL be ignored until completion; a requester SHALL NOT be regranted in the cycle after its done.
REQ-014 In IDLE, mem_a SHALL hold its last value.

Reset
REQ-015 While rst_in=0, state SHALL be IDLE and last_grant=LSB, so the icache wins the first conflict.
REQ-016 While rst_in=0, mem_a, mem_dout, mem_wr, icache_data, icache_data_valid, icache_done, lsb_rdata and lsb_done SHALL be 0.
REQ-017 Reset mid-transaction SHALL abandon it with no done pulse; a partial store may remain in memory.

Configuration
REQ-018 With MEM_ARBITER_IO_STALL_EN defined, SHALL add input io_buffer_full (1 bit).
- Write cycles with lsb_addr[17:16]==2'b11 SHALL stall: mem_wr=0, byte index held, while io_buffer_full=1.
- lsb_done SHALL be delayed by the stall count.
REQ-019 Without MEM_ARBITER_IO_STALL_EN, the io_buffer_full port SHALL be absent and writes SHALL never stall.

Structure
REQ-020 Shared package SHALL hold the state enum, the lsb_size encodings, and the IO address region constant.
REQ-021 SHALL instantiate one sub-module, mem_word_assembler: byte-lane shift/merge for lsb_rdata and byte select for mem_dout.

Verification
REQ-022 Bench SHALL cover:
- icache_req, icache_addr=0x100, ICACHE_BURST=18 -> mem_a 0x100..0x111; 18 valid bytes in cycles 1..18; icache_done in cycle 19.
- lsb load, size=01, addr=0x1003, memory 0x1003=0xAB, 0x1004=0xCD -> lsb_rdata=0x0000CDAB; lsb_done in cycle 3.
- lsb store, size=10, addr=0x2000, wdata=0x11223344 -> mem_wr 4 cycles writing 44,33,22,11; lsb_done in cycle 4.
- Both requests together after reset -> icache granted first, then LSB; repeat -> alternation.
- clear_in at IC_READ cycle 5 -> IDLE, no icache_done; clear_in during a word store -> all 4 bytes written.
- rst_in low at LS_WRITE cycle 2 -> all outputs 0 immediately; state IDLE on release.
